// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Hits complete with no stall; misses stall the CPU and sequence write-back
// and refill against a hold-until-ack data RAM. Also counts hits and misses.
module dcache_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_cs,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_din,
  output logic [31:0]           cpu_dout,
  output logic                  cpu_stall,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  input  logic                  mem_ack,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);

  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
  localparam int unsigned LINES     = 2 ** INDEX_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_GAP, S_FILL} state_t;

  state_t                 state;
  logic [31:0]            data_mem [LINES];
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]       valid;
  logic [LINES-1:0]       dirty;

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   cpu_tag;
  logic                   hit;
  logic                   idle_hit;

  // Address split and hit detection for the current CPU request
  always_comb begin
    idx       = cpu_addr[INDEX_WIDTH-1:0];
    cpu_tag   = cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    hit       = cpu_cs & valid[idx] & (tag_mem[idx] == cpu_tag);
    idle_hit  = (state == S_IDLE) & hit;
    cpu_dout  = hit ? data_mem[idx] : 32'd0;
    cpu_stall = cpu_cs & ~idle_hit;
  end

  // Line data and tag storage: written by write hits and by refills
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (idle_hit && cpu_we) begin
        data_mem[idx] <= cpu_din;
      end else if (state == S_FILL && mem_ack) begin
        data_mem[idx] <= mem_dout;
        tag_mem[idx]  <= cpu_tag;
      end
    end
  end

  // Controller FSM with registered memory-side outputs, line status and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      valid    <= '0;
      dirty    <= '0;
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '1;
      mem_din  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_cs) begin
            if (hit) begin
              hit_cnt <= hit_cnt + 16'd1;
              if (cpu_we) dirty[idx] <= 1'b1;
            end else begin
              miss_cnt <= miss_cnt + 16'd1;
              mem_cs   <= 1'b1;
              if (valid[idx] && dirty[idx]) begin
                state    <= S_WB;
                mem_we   <= 1'b1;
                mem_addr <= {tag_mem[idx], idx};
                mem_din  <= data_mem[idx];
              end else begin
                state    <= S_FILL;
                mem_we   <= 1'b0;
                mem_addr <= cpu_addr;
              end
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            state    <= S_GAP;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '1;
          end
        end
        S_GAP: begin
          // Idle address for one cycle so the RAM treats the refill as a new access
          state    <= S_FILL;
          mem_cs   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= cpu_addr;
        end
        S_FILL: begin
          if (mem_ack) begin
            state      <= S_IDLE;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '1;
          end
        end
        default: begin
          state    <= S_IDLE;
          mem_cs   <= 1'b0;
          mem_we   <= 1'b0;
          mem_addr <= '1;
        end
      endcase
    end
  end

endmodule
